fsm_arbiter: RTL and testbench

- Shares one 4-bit-input control FSM (in[3:0]/out[3:0]: IDLE, STATE_1 out=0001, STATE_2 out=0010, STATE_3 out=0100) between NUM_REQ requesters.
- Round-robin grant; the granted requester's command word is latched and sequenced into the FSM.
- Monitors FSM out until it returns to idle, then reports the visited-state bitmap and a done pulse to the winner.
- Sits between requester logic and the shared fsm instance; it is the only driver of fsm.in.

---
 rtl/fsm_arbiter.sv | 139 +++++++++++++
 tb/tb_fsm_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_arbiter.sv
// Round-robin arbiter that lends one shared control FSM to NUM_REQ requesters.
// Optional macro FSM_ARB_TIMEOUT_EN builds the HOLD_MAX wait-timeout abort path.
module fsm_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*4-1:0] req_cmd,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [3:0]           fsm_in,
    input  logic [3:0]           fsm_out,
    output logic [NUM_REQ-1:0]   done,
    output logic [3:0]           result,
    output logic                 err,
    output logic                 busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        DRIVE,
        WAIT
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   sel;
    logic            found;
    int              idx;
    logic [3:0]      cmd_q;
    logic [3:0]      acc;

    // Configurations outside the supported range elaborate this empty marker.
    if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_MAX < 4) begin : g_unsupported_params
    end

`ifdef FSM_ARB_TIMEOUT_EN
    localparam int WW = $clog2(HOLD_MAX + 1);
    logic [WW-1:0] wcnt;
    logic          err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // First requester after the previous winner, wrapping around.
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                sel   = PW'(idx);
                found = 1'b1;
            end
        end
    end

    // In WAIT the launch bits are masked so a returning FSM cannot restart.
    always_comb begin
        fsm_in = 4'b0000;
        case (state)
            DRIVE:   fsm_in = cmd_q;
            WAIT:    fsm_in = cmd_q & 4'b1100;
            default: fsm_in = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ARB_IDLE;
            rr_ptr <= PW'(NUM_REQ - 1);
            gnt    <= '0;
            cmd_q  <= 4'b0000;
            acc    <= 4'b0000;
            done   <= '0;
            result <= 4'b0000;
            busy   <= 1'b0;
`ifdef FSM_ARB_TIMEOUT_EN
            wcnt   <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            done <= '0;
            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        gnt    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
                        cmd_q  <= req_cmd[4*sel +: 4];
                        rr_ptr <= sel;
                        acc    <= 4'b0000;
                        busy   <= 1'b1;
                        state  <= DRIVE;
`ifdef FSM_ARB_TIMEOUT_EN
                        wcnt   <= '0;
`endif
                    end
                end
                DRIVE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    acc <= acc | fsm_out;
`ifdef FSM_ARB_TIMEOUT_EN
                    wcnt <= wcnt + 1'b1;
`endif
                    if (fsm_out == 4'b0000) begin
                        done   <= gnt;
                        result <= acc;
                        gnt    <= '0;
                        busy   <= 1'b0;
                        state  <= ARB_IDLE;
`ifdef FSM_ARB_TIMEOUT_EN
                        err_q  <= 1'b0;
                    end else if (wcnt == WW'(HOLD_MAX - 1)) begin
                        done   <= gnt;
                        result <= acc | fsm_out;
                        err_q  <= 1'b1;
                        gnt    <= '0;
                        busy   <= 1'b0;
                        state  <= ARB_IDLE;
`endif
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_arbiter.sv
// Self-checking bench for fsm_arbiter: transaction-level model plus directed cases.
// A small stand-in for the shared control FSM drives fsm_out.
module tb_fsm_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int HOLD_MAX = 8;
`ifdef FSM_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*4-1:0] req_cmd;
    logic [NUM_REQ-1:0]   gnt;
    logic [3:0]           fsm_in;
    logic [3:0]           fsm_out;
    logic [NUM_REQ-1:0]   done;
    logic [3:0]           result;
    logic                 err;
    logic                 busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic hold_one = 1'b0;

    fsm_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_MAX(HOLD_MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_cmd (req_cmd),
        .gnt     (gnt),
        .fsm_in  (fsm_in),
        .fsm_out (fsm_out),
        .done    (done),
        .result  (result),
        .err     (err),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in FSM: in[0] launches STATE_1, else in[1] launches STATE_2; in[3] extends to STATE_3.
    typedef enum logic [1:0] {F_IDLE, F_S1, F_S2, F_S3} fstate_t;
    fstate_t fs;
    always @(posedge clk or posedge rst) begin
        if (rst) fs <= F_IDLE;
        else begin
            case (fs)
                F_IDLE:  if (fsm_in[0]) fs <= F_S1; else if (fsm_in[1]) fs <= F_S2;
                F_S1:    fs <= F_S2;
                F_S2:    fs <= fsm_in[3] ? F_S3 : F_IDLE;
                default: fs <= F_IDLE;
            endcase
        end
    end
    assign fsm_out = hold_one ? 4'b0001 :
                     (fs == F_S1) ? 4'b0001 : (fs == F_S2) ? 4'b0010 :
                     (fs == F_S3) ? 4'b0100 : 4'b0000;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout required=event (cycle %0d)", name, cyc);
    endtask

    // Transaction-level model: owner, age since grant, accumulated visits, pointer.
    int         m_owner = -1, m_age = 0, m_ptr = NUM_REQ - 1, m_done_idx = -1, m_idx;
    logic [3:0] m_cmd = 4'b0000, m_acc = 4'b0000, m_result = 4'b0000;
    logic       m_err = 1'b0;
    logic [3:0] e_gnt, e_done, e_in;

    always @(negedge clk) begin
        if (rst) begin
            m_owner = -1; m_age = 0; m_ptr = NUM_REQ - 1; m_done_idx = -1;
            m_result = 4'b0000; m_err = 1'b0;
        end
        e_gnt  = 4'b0000;
        e_done = 4'b0000;
        e_in   = 4'b0000;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_in = (m_age == 0) ? m_cmd : (m_cmd & 4'b1100);
        end
        if (m_done_idx >= 0) e_done[m_done_idx] = 1'b1;
        checkOutput("cmp_gnt",    16'(gnt),    16'(e_gnt));
        checkOutput("cmp_fsm_in", 16'(fsm_in), 16'(e_in));
        checkOutput("cmp_done",   16'(done),   16'(e_done));
        checkOutput("cmp_result", 16'(result), 16'(m_result));
        checkOutput("cmp_err",    16'(err),    16'(m_err));
        checkOutput("cmp_busy",   16'(busy),   16'(m_owner >= 0));
        if (!rst) begin
            m_done_idx = -1;
            if (m_owner < 0) begin
                if (req != '0) begin
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        m_idx = (m_ptr + k) % NUM_REQ;
                        if (m_owner < 0 && req[m_idx]) m_owner = m_idx;
                    end
                    m_ptr = m_owner;
                    m_cmd = req_cmd[4*m_owner +: 4];
                    m_acc = 4'b0000;
                    m_age = 0;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else begin
                m_acc = m_acc | fsm_out;
                if (fsm_out == 4'b0000 || (TIMEOUT_EN && m_age >= HOLD_MAX)) begin
                    m_done_idx = m_owner;
                    m_result   = m_acc;
                    m_err      = (fsm_out != 4'b0000);
                    m_owner    = -1;
                end else begin
                    m_age++;
                end
            end
        end
    end

    task automatic waitCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] cmds);
        req     = r;
        req_cmd = cmds;
    endtask

    task automatic waitGrant(input string name, input int budget, output int at, output logic [3:0] g);
        at = -1;
        g  = 4'b0000;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (gnt != 4'b0000) begin
                at = cyc;
                g  = gnt;
                break;
            end
        end
        if (at < 0) reportTimeout(name);
    endtask

    task automatic waitDone(input string name, input int budget, output int at, output logic [3:0] d);
        at = -1;
        d  = 4'b0000;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done != 4'b0000) begin
                at = cyc;
                d  = done;
                break;
            end
        end
        if (at < 0) reportTimeout(name);
    endtask

    task automatic waitGntLow(input string name, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (gnt == 4'b0000) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) reportTimeout(name);
    endtask

    // One request from requester idx with literal expectations for the whole transaction.
    task automatic runOne(input string tag, input int idx, input logic [3:0] cmd, input logic [3:0] exp_gnt,
                          input logic [3:0] exp_wait_in, input int exp_lat, input logic [3:0] exp_res,
                          input logic exp_err);
        logic [15:0] cmds;
        logic [3:0]  r, g, d;
        int          gc, dc;
        cmds = 16'h0000;
        cmds[4*idx +: 4] = cmd;
        r = 4'b0000;
        r[idx] = 1'b1;
        waitCycle;
        applyStimulus(r, cmds);
        waitGrant({tag, "_grant"}, 10, gc, g);
        checkOutput({tag, "_gnt"}, 16'(g), 16'(exp_gnt));
        checkOutput({tag, "_drive_in"}, 16'(fsm_in), 16'(cmd));
        waitCycle;
        applyStimulus(4'b0000, 16'h0000);
        @(negedge clk);
        checkOutput({tag, "_wait_in"}, 16'(fsm_in), 16'(exp_wait_in));
        waitDone({tag, "_done"}, 30, dc, d);
        checkOutput({tag, "_done_vec"}, 16'(d), 16'(exp_gnt));
        checkOutput({tag, "_latency"}, 16'(dc - gc), 16'(exp_lat));
        checkOutput({tag, "_result"}, 16'(result), 16'(exp_res));
        checkOutput({tag, "_err"}, 16'(err), 16'(exp_err));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] exp_rr [5];
        logic [3:0] g, d;
        int         gc, dc, prev;
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev   = 0;

        rst = 1'b1;
        applyStimulus(4'b1111, 16'h0000);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_gnt",    16'(gnt),    16'h0);
            checkOutput("rst_fsm_in", 16'(fsm_in), 16'h0);
            checkOutput("rst_done",   16'(done),   16'h0);
            checkOutput("rst_busy",   16'(busy),   16'h0);
        end
        waitCycle;
        rst = 1'b0;

        $display("[TB] round-robin with all requesters and idle commands");
        for (int i = 0; i < 5; i++) begin
            waitGrant("rr_grant", 12, gc, g);
            checkOutput("rr_gnt", 16'(g), 16'(exp_rr[i]));
            if (i > 0) checkOutput("rr_period", 16'(gc - prev), 16'd3);
            prev = gc;
            if (i < 4) waitGntLow("rr_release", 6);
        end
        waitCycle;
        applyStimulus(4'b0000, 16'h0000);
        waitDone("rr_last_done", 10, dc, d);
        checkOutput("rr_last_result", 16'(result), 16'h0);
        repeat (2) waitCycle;

        $display("[TB] single transactions");
        runOne("t_req0_0101", 0, 4'b0101, 4'b0001, 4'b0100, 4, 4'b0011, 1'b0);
        runOne("t_req2_1101", 2, 4'b1101, 4'b0100, 4'b1100, 5, 4'b0111, 1'b0);
        runOne("t_req1_0010", 1, 4'b0010, 4'b0010, 4'b0000, 3, 4'b0010, 1'b0);
        runOne("t_req3_1011", 3, 4'b1011, 4'b1000, 4'b1000, 5, 4'b0111, 1'b0);

        $display("[TB] FSM output held non-idle");
        waitCycle;
        hold_one = 1'b1;
`ifdef FSM_ARB_TIMEOUT_EN
        runOne("t_timeout", 1, 4'b0001, 4'b0010, 4'b0000, HOLD_MAX + 1, 4'b0001, 1'b1);
        waitCycle;
        hold_one = 1'b0;
`else
        begin
            logic quiet;
            waitCycle;
            applyStimulus(4'b0010, 16'h0010);
            waitGrant("hold_grant", 10, gc, g);
            checkOutput("hold_gnt", 16'(g), 16'h2);
            waitCycle;
            applyStimulus(4'b0000, 16'h0000);
            quiet = 1'b1;
            repeat (HOLD_MAX + 6) begin
                @(negedge clk);
                if (done != 4'b0000) quiet = 1'b0;
            end
            checkOutput("hold_no_done", 16'(quiet), 16'h1);
            checkOutput("hold_busy", 16'(busy), 16'h1);
            waitCycle;
            hold_one = 1'b0;
            waitDone("hold_done", 10, dc, d);
            checkOutput("hold_done_vec", 16'(d), 16'h2);
            checkOutput("hold_result", 16'(result), 16'h1);
            checkOutput("hold_err", 16'(err), 16'h0);
        end
`endif

        $display("[TB] reset during a transaction");
        waitCycle;
        applyStimulus(4'b1000, 16'hD000);
        waitGrant("mid_grant", 10, gc, g);
        checkOutput("mid_gnt", 16'(g), 16'h8);
        waitCycle;
        applyStimulus(4'b0000, 16'h0000);
        waitCycle;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_gnt",    16'(gnt),    16'h0);
        checkOutput("mid_rst_fsm_in", 16'(fsm_in), 16'h0);
        checkOutput("mid_rst_busy",   16'(busy),   16'h0);
        checkOutput("mid_rst_done",   16'(done),   16'h0);
        repeat (2) waitCycle;
        rst = 1'b0;
        applyStimulus(4'b1001, 16'h0000);
        waitGrant("post_rst_grant", 10, gc, g);
        checkOutput("post_rst_gnt", 16'(g), 16'h1);
        waitCycle;
        applyStimulus(4'b0000, 16'h0000);
        waitDone("post_rst_done", 10, dc, d);
        checkOutput("post_rst_done_vec", 16'(d), 16'h1);
        checkOutput("post_rst_latency", 16'(dc - gc), 16'd2);
        repeat (3) waitCycle;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
